// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO unit: datapath width, SPECIAL funct codes
// and a small two's-complement helper.
package mult_div_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Magnitude of a two's-complement word. The most-negative value maps to
    // itself, which is the correct unsigned magnitude 2^31.
    function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle. The quotient and
// remainder outputs are the result of the step being performed this cycle,
// so the final values are available while ready is high.
module div_core
    import mult_div_unit_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;

    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_d;
    logic [DATA_W-1:0] quo_d;

    // One restoring step: shift rem:quo left, trial-subtract, keep if non-negative.
    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_bit  = ~diff[DATA_W];
        rem_d  = q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_d  = {quo_q[DATA_W-2:0], q_bit};
    end

    assign busy      = busy_q;
    assign ready     = busy_q && (cnt_q == LAST_CNT);
    assign quotient  = quo_d;
    assign remainder = rem_d;

    // Iteration counter and shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU, multi-cycle DIV/DIVU via
// div_core, MTHI/MTLO writes, and the pipeline stall request.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] operand_1,
    input  logic [DATA_W-1:0] operand_2,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                is_mul, is_div, is_signed, op2_zero;
    logic                accept, mul_commit, div_start, div_commit;
    logic [2*DATA_W-1:0] ext_1, ext_2, product;
    logic                div_busy, div_ready;
    logic [DATA_W-1:0]   div_quo, div_rem, quo_fix, rem_fix;
    logic                neg_quo_q, neg_rem_q;
    logic [DATA_W-1:0]   hi_q, lo_q;

    assign is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign op2_zero  = (operand_2 == '0);

    assign accept     = (state_q == ST_IDLE) && start && (is_mul || is_div) && !flush;
    assign mul_commit = accept && is_mul;
    assign div_start  = accept && is_div && !op2_zero;
    assign div_commit = (state_q == ST_DIV) && div_ready && !flush;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both MULT and MULTU.
    always_comb begin
        ext_1   = is_signed ? {{DATA_W{operand_1[DATA_W-1]}}, operand_1} : {{DATA_W{1'b0}}, operand_1};
        ext_2   = is_signed ? {{DATA_W{operand_2[DATA_W-1]}}, operand_2} : {{DATA_W{1'b0}}, operand_2};
        product = ext_1 * ext_2;
    end

    div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (is_signed ? abs_w(operand_1) : operand_1),
        .divisor   (is_signed ? abs_w(operand_2) : operand_2),
        .busy      (div_busy),
        .ready     (div_ready),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
    always_comb begin
        quo_fix = neg_quo_q ? (~div_quo + 1'b1) : div_quo;
        rem_fix = neg_rem_q ? (~div_rem + 1'b1) : div_rem;
    end

    // Capture operand signs when a signed divide is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (div_start) begin
            neg_quo_q <= is_signed && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
            neg_rem_q <= is_signed && operand_1[DATA_W-1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall/done outputs; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall_req = 1'b1;
                    state_d   = div_start ? ST_DIV : ST_DONE;
                end
            end
            ST_DIV: begin
                stall_req = 1'b1;
                if (div_ready) begin
                    state_d = ST_DONE;
                end else if (!div_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d   = ST_IDLE;
            stall_req = 1'b0;
        end
    end

    // HI/LO: result commits win over MTHI/MTLO writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mul_commit) begin
            hi_q <= product[2*DATA_W-1:DATA_W];
            lo_q <= product[DATA_W-1:0];
        end else if (div_commit) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
        end else begin
            if (hi_we) hi_q <= hi_wdata;
            if (lo_we) lo_q <= lo_wdata;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// flush/reset sequences, and randomized operations against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h0;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi_wdata = '0;
    logic [31:0] lo_wdata = '0;
    logic        stall_req, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit #(.DIV_ITER(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the architectural definition.
    task automatic ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                          output logic [31:0] nh, output logic [31:0] nl, output int lat);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        nh = cur_hi;
        nl = cur_lo;
        lat = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h18: begin p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0]; end
            6'h19: begin p = 64'(a) * 64'(b); nh = p[63:32]; nl = p[31:0]; end
            6'h1A: if (b != 0) begin
                sq = sa / sb; sr = sa % sb;
                p = 64'(sq); nl = p[31:0];
                p = 64'(sr); nh = p[31:0];
                lat = 33;
            end
            default: if (b != 0) begin
                nl = a / b; nh = a % b; lat = 33;
            end
        endcase
    endtask

    // Issue one op holding start until done (as the pipeline would), then
    // check latency, stall length, result, and that no second op launches.
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int exp_lat);
        int cyc = 0;
        int stalls = 0;
        bit seen = 0;
        @(negedge clk);
        start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
        while (cyc < 60 && !seen) begin
            #1;
            if (done) seen = 1;
            else begin
                if (stall_req) stalls++;
                cyc++;
                @(negedge clk);
            end
        end
        $display("op %s f=%h a=%h b=%h -> hi=%h lo=%h done_cycle=%0d stalls=%0d",
                 name, f, a, b, hi, lo, cyc, stalls);
        chk({name, "_done_cycle"}, 64'(cyc), 64'(exp_lat));
        chk({name, "_stalls"}, 64'(stalls), 64'(exp_lat));
        chk({name, "_stall_in_done"}, 64'(stall_req), 64'(0));
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({name, "_no_relaunch"}, 64'({done, stall_req}), 64'(0));
    endtask

    task automatic mt(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = h; lo_wdata = l;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        #1;
        $display("mthi/mtlo hi=%h lo=%h", hi, lo);
        chk("mt_hi", 64'(hi), 64'(h));
        chk("mt_lo", 64'(lo), 64'(l));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [31:0] mh, ml, nh, nl;
        logic [5:0]  rf;
        logic [31:0] ra, rb;
        int          lat, dones;

        vecs[0] = '{6'h18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1};
        vecs[1] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
        vecs[2] = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3] = '{6'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[4] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5] = '{6'h1A, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[6] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1};
        vecs[7] = '{6'h1B, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_stall", 64'(stall_req), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].eh, vecs[i].el, vecs[i].lat);
        end

        // Divide by zero keeps preloaded HI/LO.
        mt(32'h1234, 32'h5678);
        run_op("divu_by_zero", 6'h1B, 32'd5, 32'd0, 32'h1234, 32'h5678, 1);

        // Flush in C10 of a DIV, then MULT accepted in C11.
        @(negedge clk);
        start = 1'b1; funct = 6'h1A; operand_1 = 32'd1000; operand_2 = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall_c10", 64'(stall_req), 64'(0));
        @(negedge clk);
        flush = 1'b0; funct = 6'h18; operand_1 = 32'd6; operand_2 = 32'hFFFFFFF9;
        #1;
        $display("flush C11 stall=%b hi=%h lo=%h", stall_req, hi, lo);
        chk("flush_accept_c11", 64'(stall_req), 64'(1));
        chk("flush_hi_kept", 64'(hi), 64'(32'h1234));
        chk("flush_lo_kept", 64'(lo), 64'(32'h5678));
        @(negedge clk);
        #1;
        $display("flush C12 done=%b hi=%h lo=%h", done, hi, lo);
        chk("flush_mult_done", 64'(done), 64'(1));
        chk("flush_mult_hi", 64'(hi), 64'(32'hFFFFFFFF));
        chk("flush_mult_lo", 64'(lo), 64'(32'hFFFFFFD6));
        @(negedge clk);
        start = 1'b0;

        // Reset in C5 of a DIV.
        mt(32'hAAAA, 32'hBBBB);
        @(negedge clk);
        start = 1'b1; funct = 6'h1B; operand_1 = 32'd1000; operand_2 = 32'd3;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("rst_mid_hi", 64'(hi), 64'(0));
        chk("rst_mid_lo", 64'(lo), 64'(0));
        chk("rst_mid_stall", 64'(stall_req), 64'(0));
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dones++;
            @(negedge clk);
            #1;
        end
        $display("reset mid-div: hi=%h lo=%h dones_after=%0d", hi, lo, dones);
        chk("rst_no_done", 64'(dones), 64'(0));
        run_op("post_rst_mult", 6'h18, 32'd3, 32'd4, 32'd0, 32'd12, 1);

        // Randomized ops against the model.
        mh = 32'd0; ml = 32'd12;
        for (int i = 0; i < 40; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            ref_op(rf, ra, rb, mh, ml, nh, nl, lat);
            run_op($sformatf("rand%0d", i), rf, ra, rb, nh, nl, lat);
            mh = nh; ml = nl;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage HI/LO unit for the MIPS core. It consumes the `operand_1`/`operand_2` pair that ID operand generation produces for SPECIAL-opcode instructions. It executes MULT/MULTU in a single cycle and DIV/DIVU as a 32-iteration restoring divider, and owns the architectural HI/LO registers. While busy it raises a pipeline stall request so the instruction holds in EX.

## Interface
Parameters:
- `DIV_ITER`, 32: number of divider iterations, one quotient bit per cycle.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  EX holds a SPECIAL instruction. Qualified by `funct`.
- `funct`  in  6  funct field: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other value with `start` is ignored.
- `operand_1`  in  32  rs value (dividend / multiplicand).
- `operand_2`  in  32  rt value (divisor / multiplier).
- `flush`  in  1  pipeline flush. Aborts any in-flight operation.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables.
- `hi_wdata`, `lo_wdata`  in  32  MTHI/MTLO data.
- `stall_req`  out  1  hold the pipeline (combinational).
- `done`  out  1  one-cycle pulse: result committed to HI/LO.
- `hi`, `lo`  out  32  registered HI/LO (MFHI/MFLO source).

## Operation
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - `start` with MULT/MULTU: compute the 64-bit product (signed for MULT, unsigned for MULTU) and write HI=[63:32], LO=[31:0] at the clock edge. Go to DONE.
  - `start` with DIV/DIVU and `operand_2` != 0: latch divisor and dividend magnitudes. For DIV, take the absolute value of each operand and record sign(dividend) and sign(dividend) XOR sign(divisor); for DIVU, use the operands unmodified. Clear the iteration counter and go to DIV.
  - `start` with DIV/DIVU and `operand_2` == 0: HI/LO are not modified. Go to DONE.
- DIV:
  - Each cycle performs one restoring step: shift remainder:quotient left 1, trial-subtract the divisor, keep the difference and set the quotient bit if it is non-negative.
  - The counter increments each cycle. After iteration `DIV_ITER` (counter == 31), apply the sign fix-up and write the result at that edge, then go to DONE.
  - Sign fix-up: quotient negated if signs differed; remainder takes the dividend's sign. LO=quotient, HI=remainder.
- DONE:
  - `done`=1, `stall_req`=0, return to IDLE.
  - `start` is ignored here: the same instruction is still presented while the pipeline advances.
- `stall_req` = (IDLE && `start` && funct ∈ {MULT,MULTU,DIV,DIVU} && !`flush`) || state==DIV.
- MTHI/MTLO write on `hi_we`/`lo_we` in any state. A result commit in the same cycle takes priority. The pipeline never produces this overlap.
- `flush`: in any state, next state is IDLE, no HI/LO commit, and `stall_req` is forced 0 in the same cycle. `flush` and `start` together: `flush` wins.
- Arithmetic: all 32-bit values are two's complement. abs(0x80000000) = 0x80000000 treated as unsigned, which gives the correct result for the most-negative dividend. MIPS overflow (0x80000000 / -1) gives LO=0x80000000, HI=0.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `done`=0, `stall_req`=0, counter 0, datapath registers 0.
- MULT/MULTU:
  - Accept cycle C0: `stall_req`=1, HI/LO updated at the end of C0.
  - C1: DONE, `done`=1, `stall_req`=0.
  - Total stall is 1 cycle.
- DIV/DIVU:
  - C0: accept, `stall_req`=1.
  - C1..C32: iterations, `stall_req`=1. The commit happens at the end of C32.
  - C33: DONE, `done`=1, `stall_req`=0.
  - Total stall is 33 cycles.
- Divide by zero: same timing as MULT (1 stall cycle, `done` in C1), HI/LO unchanged.
- `hi`/`lo` show the new value from the cycle after the commit edge. There is no combinational bypass.
- `rst` mid-operation: next cycle is in reset state with HI/LO cleared. No `done` pulse.
- Back-to-back: a new `start` is accepted in the IDLE cycle immediately after DONE.

## Structure
- The funct constants `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT_MTHI`, `FUNCT_MTLO` belong in the shared funct header.
- Data-width macros come from the shared bus header.
- FSM state encodings stay local to the block.
- One sub-module, `div_core`:
  - Unsigned restoring divider with ports start/abort/busy/ready, dividend, divisor, quotient, remainder.
  - Contains the counter and the shift registers.
  - `mult_div_unit` wraps it with the sign handling, multiplier, FSM and HI/LO.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; `stall_req` high exactly 1 cycle; `done` in C1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; `stall_req` high 33 cycles; `done` in C33. DIVU 100/7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5 / 0 -> HI/LO keep their prior values (preload via MTHI=0x1234, MTLO=0x5678); 1 stall cycle.
- `flush` asserted in C10 of a DIV -> `stall_req`=0 in C10; IDLE in C11; HI/LO unchanged; a new MULT with `start` in C11 is accepted and commits correctly.
- `rst` asserted in C5 of a DIV -> HI=LO=0, IDLE, no `done` pulse. `start` held high through DONE -> no second operation launched.
